// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-frame master and its controller.
// Frame layout: {wr, 3'b000, addr[3:0], data[7:0]}, sent MSB first.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int WR_BIT     = 15;
  localparam int ADDR_MSB   = 11;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Reads carry a zero data byte; the slave answers on MISO instead.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                        input logic [3:0] addr,
                                                        input logic [7:0] wdata);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[WR_BIT]            = wr;
    f[ADDR_MSB:ADDR_LSB] = addr;
    if (wr) f[DATA_MSB:0] = wdata;
    return f;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response handshake of the SPI master.
// The requesting controller uses the master modport, spi_master uses slave.
interface spi_master_if;

  logic       start;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;

  modport master (output start, wr, addr, wdata, input ready, done, rdata);
  modport slave  (input start, wr, addr, wdata, output ready, done, rdata);

endinterface

// File: rtl/spi_clkgen.sv
// SCLK generator: CLK_DIV-cycle half periods while enabled, idles low.
// Strobes flag the clk edge on which spi_clk will rise or fall.
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic spi_clk
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc       = en && (cnt == '0);
  assign rise_stb = tc && !spi_clk;
  assign fall_stb = tc && spi_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= RELOAD;
      spi_clk <= 1'b0;
    end else if (!en) begin
      cnt     <= RELOAD;
      spi_clk <= 1'b0;
    end else if (tc) begin
      cnt     <= RELOAD;
      spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master issuing one 16-bit register frame per host handshake.
//   state | meaning
//   IDLE  | ready, waiting for start
//   SETUP | CS low, SCLK idle, CS_SETUP cycles
//   SHIFT | 16 SCLK periods, MOSI out / MISO in
//   HOLD  | CS low after last SCLK fall, CS_HOLD cycles
//   GAP   | CS high recovery, CS_HOLD cycles, then done
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_if.slave        bus,
  output logic               spi_clk,
  output logic               spi_cs,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  localparam int            TMAX     = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int            TW       = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD - 1);

  state_t                state;
  logic [TW-1:0]         tmr;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx;
  logic [7:0]            rx;
  logic                  is_rd;
  logic                  shift_en;
  logic                  rise_stb;
  logic                  fall_stb;

  assign shift_en = (state == ST_SHIFT);

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .spi_clk  (spi_clk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      is_rd     <= 1'b0;
      spi_cs    <= 1'b1;
      spi_mosi  <= 1'b0;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && bus.ready) begin
            tx        <= build_frame(bus.wr, bus.addr, bus.wdata);
            spi_mosi  <= bus.wr;
            spi_cs    <= 1'b0;
            bus.ready <= 1'b0;
            is_rd     <= !bus.wr;
            tmr       <= SETUP_LD;
            bit_cnt   <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr == '0) state <= ST_SHIFT;
          else           tmr   <= tmr - 1'b1;
        end
        ST_SHIFT: begin
          // Only the last 8 bits received matter: they are the read data.
          if (rise_stb) rx <= {rx[6:0], spi_miso};
          if (fall_stb) begin
            if (bit_cnt == 4'd15) begin
              spi_mosi <= 1'b0;
              tmr      <= HOLD_LD;
              state    <= ST_HOLD;
            end else begin
              tx       <= {tx[FRAME_BITS-2:0], tx[FRAME_BITS-1]};
              spi_mosi <= tx[FRAME_BITS-2];
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tmr == '0) begin
            spi_cs <= 1'b1;
            tmr    <= HOLD_LD;
            state  <= ST_GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            state     <= ST_IDLE;
            bus.ready <= 1'b1;
            bus.done  <= 1'b1;
            if (is_rd) bus.rdata <= rx;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default and minimum-timing instances,
// each talking to a behavioural register-slave model.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, wr, ready, done, sclk, cs, mosi, miso;
  logic [3:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];

  int total = 0;
  int bad   = 0;

  spi_master_if bus0 ();
  spi_master_if bus1 ();

  assign bus0.start = start[0];
  assign bus0.wr    = wr[0];
  assign bus0.addr  = addr[0];
  assign bus0.wdata = wdata[0];
  assign ready[0]   = bus0.ready;
  assign done[0]    = bus0.done;
  assign rdata[0]   = bus0.rdata;
  assign bus1.start = start[1];
  assign bus1.wr    = wr[1];
  assign bus1.addr  = addr[1];
  assign bus1.wdata = wdata[1];
  assign ready[1]   = bus1.ready;
  assign done[1]    = bus1.done;
  assign rdata[1]   = bus1.rdata;

  spi_master u_dut0 (
    .clk(clk), .rst(rst[0]), .bus(bus0),
    .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .bus(bus1),
    .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  function automatic int pd(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int ps(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int ph(input int i); return (i == 0) ? 2 : 1; endfunction

  function automatic logic [7:0] init_val(input int a);
    return 8'(8'h37 + a);
  endfunction

  // Register slave: samples MOSI on SCLK rise, shifts read data out on falls.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic [7:0]  mem [16];
    logic [15:0] sh;
    logic [7:0]  out;
    logic        so;
    int          cnt;
    initial begin
      for (int a = 0; a < 16; a++) mem[a] = init_val(a);
      sh  = '0;
      out = '0;
      so  = 1'b0;
      cnt = 0;
    end
    assign miso[g] = so;
    always @(posedge sclk[g] or posedge cs[g]) begin
      if (cs[g]) cnt = 0;
      else begin
        sh  = {sh[14:0], mosi[g]};
        cnt = cnt + 1;
        if (cnt == 16 && sh[15]) mem[sh[11:8]] = sh[7:0];
      end
    end
    always @(negedge sclk[g]) begin
      if (!cs[g]) begin
        if (cnt == 8) out = sh[7] ? 8'h00 : mem[sh[3:0]];
        else          out = {out[6:0], 1'b0};
        so = out[7];
      end
    end
  end

  // Reference model of the register contents and the last read result.
  logic [7:0] ref_mem [2][16];
  logic [7:0] ref_rd  [2];

  typedef struct {
    bit         w;
    logic [3:0] a;
    logic [7:0] d;
    logic [15:0] ef;
    logic [7:0] er;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input bit s);
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    start[i] = s;
  endtask

  task automatic model_update(input int i, input bit w, input logic [3:0] a,
                              input logic [7:0] d);
    if (w) ref_mem[i][a] = d;
    else   ref_rd[i]     = ref_mem[i][a];
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_frame(input int i, input bit w, input logic [3:0] a,
                           input logic [7:0] d, input logic [15:0] ef,
                           input logic [7:0] er, input int pulse_at,
                           output int hi_tail);
    int k, cs_low, rises, first, second, got, rdy_bad;
    logic [15:0] frame;
    logic prev;
    k = ps(i) + 32 * pd(i) + 2 * ph(i);
    cs_low = 0; rises = 0; first = -1; second = -1; got = -1; rdy_bad = 0;
    frame = '0; hi_tail = 0; prev = sclk[i];
    chk("ready_idle", ready[i], 1);
    drive(i, w, a, d, 1'b1);
    for (int n = 1; n <= k + 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start[i] = 1'b0;
        chk("cs_fall", cs[i], 0);
      end
      if (n == pulse_at) drive(i, !w, a + 4'd1, ~d, 1'b1);
      if (n == pulse_at + 1) start[i] = 1'b0;
      if (!cs[i]) begin cs_low++; hi_tail = 0; end
      else hi_tail++;
      if (sclk[i] && !prev) begin
        rises++;
        frame = {frame[14:0], mosi[i]};
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      prev = sclk[i];
      if (done[i]) begin got = n; break; end
      if (ready[i]) rdy_bad++;
    end
    chk("done_at", got, k + 1);
    chk("cs_low", cs_low, ps(i) + 32 * pd(i) + ph(i));
    chk("rises", rises, 16);
    chk("mosi_frame", frame, ef);
    chk("first_rise", first, ps(i) + pd(i) + 1);
    chk("sclk_period", second - first, 2 * pd(i));
    chk("ready_busy", rdy_bad, 0);
    chk("ready_done", ready[i], 1);
    chk("rdata", rdata[i], er);
  endtask

  task automatic frame_model(input int i, input bit w, input logic [3:0] a,
                             input logic [7:0] d, input int pulse_at,
                             output int hi_tail);
    logic [15:0] ef;
    logic [7:0]  er;
    ef = 16'(int'(w) * 32768 + int'(a) * 256 + (w ? int'(d) : 0));
    er = w ? ref_rd[i] : ref_mem[i][a];
    run_frame(i, w, a, d, ef, er, pulse_at, hi_tail);
    model_update(i, w, a, d);
  endtask

  initial begin
    int hi, hi2, rises, dcnt;
    logic prev;
    bit w;
    logic [3:0] a;
    logic [7:0] d;

    tbl[0] = '{1'b1, 4'h3, 8'hA5, 16'h83A5, 8'h00};
    tbl[1] = '{1'b0, 4'h5, 8'h00, 16'h0500, 8'h3C};
    tbl[2] = '{1'b1, 4'h5, 8'h11, 16'h8511, 8'h3C};
    tbl[3] = '{1'b0, 4'h5, 8'hFF, 16'h0500, 8'h11};
    tbl[4] = '{1'b0, 4'h0, 8'h00, 16'h0000, 8'h37};
    tbl[5] = '{1'b1, 4'hF, 8'hFF, 16'h8FFF, 8'h37};
    tbl[6] = '{1'b0, 4'hF, 8'h00, 16'h0F00, 8'hFF};

    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 16; r++) ref_mem[i][r] = init_val(r);
      ref_rd[i] = 8'h00;
      drive(i, 1'b0, 4'h0, 8'h00, 1'b0);
    end
    rst = 2'b11;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", ready[i], 1);
      chk("rst_done", done[i], 0);
      chk("rst_rdata", rdata[i], 0);
      chk("rst_sclk", sclk[i], 0);
      chk("rst_cs", cs[i], 1);
      chk("rst_mosi", mosi[i], 0);
    end
    rst = 2'b00;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_frame(0, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].ef, tbl[v].er, -1, hi);
      model_update(0, tbl[v].w, tbl[v].a, tbl[v].d);
      @(negedge clk);
      chk("done_pulse", done[0], 0);
    end

    // start pulsed mid-SHIFT with another command must not disturb the frame
    frame_model(0, 1'b0, 4'h3, 8'h00, 40, hi);
    @(negedge clk);

    // back-to-back: second start presented in the done cycle
    frame_model(0, 1'b1, 4'h9, 8'h66, -1, hi);
    frame_model(0, 1'b0, 4'h9, 8'h00, -1, hi2);
    chk("b2b_gap", hi, ph(0) + 1);
    @(negedge clk);

    // reset after the 6th SCLK rise aborts the frame without done
    drive(0, 1'b0, 4'h5, 8'h00, 1'b1);
    rises = 0;
    prev  = sclk[0];
    for (int n = 0; n < 200 && rises < 6; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
    end
    chk("abort_reach6", rises, 6);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_cs", cs[0], 1);
    chk("abort_sclk", sclk[0], 0);
    chk("abort_mosi", mosi[0], 0);
    chk("abort_ready", ready[0], 1);
    chk("abort_done", done[0], 0);
    chk("abort_rdata", rdata[0], 0);
    rst[0] = 1'b0;
    ref_rd[0] = 8'h00;
    dcnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done[0]) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    frame_model(0, 1'b0, 4'h5, 8'h00, -1, hi);
    @(negedge clk);

    // minimum-timing instance: loopback write/read
    frame_model(1, 1'b1, 4'h9, 8'h5A, -1, hi);
    @(negedge clk);
    frame_model(1, 1'b0, 4'h9, 8'h00, -1, hi);
    chk("corner_loop", rdata[1], 8'h5A);
    @(negedge clk);

    for (int r = 0; r < 16; r++) begin
      int i;
      i = (r < 6) ? 0 : 1;
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      frame_model(i, w, a, d, -1, hi);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
